// File: rtl/la_regfile_sb.sv
// rtl/la_regfile_sb.sv - 2R/1W register file with write bypass and RAW busy scoreboard
module la_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rR1,
    input  logic [ADDR_W-1:0] rR2,
    input  logic              rd1_use_wr,
    input  logic [ADDR_W-1:0] wR,
    input  logic              we,
    input  logic              link_we,
    input  logic [DATA_W-1:0] wD,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic [DATA_W-1:0] rD1,
    output logic [DATA_W-1:0] rD2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;

    logic [ADDR_W-1:0] w_ew;
    logic [ADDR_W-1:0] w_r1;
    logic              w_wr;
    logic              w_set;

    assign w_ew  = link_we ? ADDR_W'(LINK_REG) : wR;
    assign w_wr  = rst_n && (we || link_we) && (w_ew != '0);
    assign w_set = issue_valid && (issue_reg != '0);
    assign w_r1  = rd1_use_wr ? wR : rR1;

    // Set is applied after clear so a newer producer issued this cycle stays outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr) begin
                r_regs[w_ew] <= wD;
                r_busy[w_ew] <= 1'b0;
            end
            if (w_set) begin
                r_busy[issue_reg] <= 1'b1;
            end
        end
    end

    always_comb begin
        rD1   = (w_r1 == '0) ? '0 : r_regs[w_r1];
        busy1 = (w_r1 == '0) ? 1'b0 : r_busy[w_r1];
        if ((BYPASS != 0) && w_wr && (w_ew == w_r1) && (w_r1 != '0)) begin
            rD1 = wD;
            if (!(w_set && (issue_reg == w_r1))) begin
                busy1 = 1'b0;
            end
        end
    end

    always_comb begin
        rD2   = (rR2 == '0) ? '0 : r_regs[rR2];
        busy2 = (rR2 == '0) ? 1'b0 : r_busy[rR2];
        if ((BYPASS != 0) && w_wr && (w_ew == rR2) && (rR2 != '0)) begin
            rD2 = wD;
            if (!(w_set && (issue_reg == rR2))) begin
                busy2 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_la_regfile_sb.sv
// tb/tb_la_regfile_sb.sv - directed vector bench for la_regfile_sb (bypass, no-bypass, wide)
module tb_la_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rR1, rR2, wR, issue_reg;
    logic        rd1_use_wr, we, link_we, issue_valid;
    logic [31:0] wD;
    logic [31:0] rD1, rD2, n_rD1, n_rD2;
    logic        busy1, busy2, n_busy1, n_busy2;

    logic [3:0]  x_rR1, x_rR2, x_wR, x_issue_reg;
    logic        x_use_wr, x_we, x_link_we, x_issue_valid;
    logic [63:0] x_wD, x_rD1, x_rD2;
    logic        x_busy1, x_busy2;

    int errors = 0;
    int checks = 0;

    la_regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rR1(rR1), .rR2(rR2), .rd1_use_wr(rd1_use_wr),
        .wR(wR), .we(we), .link_we(link_we), .wD(wD),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .rD1(rD1), .rD2(rD2), .busy1(busy1), .busy2(busy2)
    );

    la_regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rR1(rR1), .rR2(rR2), .rd1_use_wr(rd1_use_wr),
        .wR(wR), .we(we), .link_we(link_we), .wD(wD),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .rD1(n_rD1), .rD2(n_rD2), .busy1(n_busy1), .busy2(n_busy2)
    );

    la_regfile_sb #(.DATA_W(64), .ADDR_W(4), .LINK_REG(1), .BYPASS(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .rR1(x_rR1), .rR2(x_rR2), .rd1_use_wr(x_use_wr),
        .wR(x_wR), .we(x_we), .link_we(x_link_we), .wD(x_wD),
        .issue_valid(x_issue_valid), .issue_reg(x_issue_reg),
        .rD1(x_rD1), .rD2(x_rD2), .busy1(x_busy1), .busy2(x_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we, link_we, use_wr, iv;
        logic [4:0]  wr, r1, r2, ireg;
        logic [31:0] wd;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [31:0] n_rd1, n_rd2;
        logic        n_b1, n_b2;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we link uw iv | wR rR1 rR2 ireg | wD | bypass rd1 rd2 b1 b2 | no-bypass rd1 rd2 b1 b2
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0,5'd0, 32'h1234,     32'h0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0,5'd0, 32'h0,        32'h0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 5'd7,5'd1,5'd7,5'd0, 32'h80,       32'h80,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd1,5'd7,5'd0, 32'h0,        32'h80,32'h0,1'b0,1'b0, 32'h80,32'h0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 5'd9,5'd0,5'd0,5'd0, 32'h11111111, 32'h0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 5'd9,5'd9,5'd9,5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5,32'hA5A5A5A5,1'b0,1'b0, 32'h11111111,32'h11111111,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd9,5'd9,5'd0, 32'h0,        32'hA5A5A5A5,32'hA5A5A5A5,1'b0,1'b0, 32'hA5A5A5A5,32'hA5A5A5A5,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 5'd3,5'd0,5'd0,5'd0, 32'h11,       32'h0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 5'd4,5'd3,5'd4,5'd0, 32'h22,       32'h11,32'h22,1'b0,1'b0, 32'h11,32'h0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0, 5'd4,5'd3,5'd3,5'd0, 32'h0,        32'h22,32'h11,1'b0,1'b0, 32'h22,32'h11,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1, 5'd0,5'd6,5'd6,5'd6, 32'h0,        32'h0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd6,5'd6,5'd0, 32'h0,        32'h0,32'h0,1'b1,1'b1, 32'h0,32'h0,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 5'd6,5'd6,5'd6,5'd0, 32'h66,       32'h66,32'h66,1'b0,1'b0, 32'h0,32'h0,1'b1,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd6,5'd6,5'd0, 32'h0,        32'h66,32'h66,1'b0,1'b0, 32'h66,32'h66,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1, 5'd0,5'd6,5'd6,5'd6, 32'h0,        32'h66,32'h66,1'b0,1'b0, 32'h66,32'h66,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b1, 5'd6,5'd6,5'd6,5'd6, 32'h77,       32'h77,32'h77,1'b1,1'b1, 32'h66,32'h66,1'b1,1'b1};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd6,5'd6,5'd0, 32'h0,        32'h77,32'h77,1'b1,1'b1, 32'h77,32'h77,1'b1,1'b1};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b1, 5'd0,5'd0,5'd6,5'd0, 32'h0,        32'h0,32'h77,1'b0,1'b1, 32'h0,32'h77,1'b0,1'b1};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0, 5'd6,5'd6,5'd0,5'd0, 32'h88,       32'h88,32'h0,1'b0,1'b0, 32'h77,32'h0,1'b1,1'b0};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b0, 5'd0,5'd6,5'd0,5'd0, 32'h0,        32'h88,32'h0,1'b0,1'b0, 32'h88,32'h0,1'b0,1'b0};

        rst_n = 1'b0;
        {rR1, rR2, wR, issue_reg} = '0;
        {rd1_use_wr, we, link_we, issue_valid} = '0;
        wD = '0;
        {x_rR1, x_rR2, x_wR, x_issue_reg} = '0;
        {x_use_wr, x_we, x_link_we, x_issue_valid} = '0;
        x_wD = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        rR1 = 5'd5; rR2 = 5'd31;
        #1;
        chk("reset_rd1", {32'h0, rD1}, 64'h0);
        chk("reset_rd2", {32'h0, rD2}, 64'h0);
        chk("reset_busy1", {63'h0, busy1}, 64'h0);
        chk("reset_busy2", {63'h0, busy2}, 64'h0);
        tick();

        for (int i = 0; i < 20; i++) begin
            we = vecs[i].we; link_we = vecs[i].link_we; rd1_use_wr = vecs[i].use_wr;
            issue_valid = vecs[i].iv; wR = vecs[i].wr; rR1 = vecs[i].r1; rR2 = vecs[i].r2;
            issue_reg = vecs[i].ireg; wD = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_rd1", i), {32'h0, rD1}, {32'h0, vecs[i].e_rd1});
            chk($sformatf("v%0d_rd2", i), {32'h0, rD2}, {32'h0, vecs[i].e_rd2});
            chk($sformatf("v%0d_busy1", i), {63'h0, busy1}, {63'h0, vecs[i].e_b1});
            chk($sformatf("v%0d_busy2", i), {63'h0, busy2}, {63'h0, vecs[i].e_b2});
            chk($sformatf("v%0d_nb_rd1", i), {32'h0, n_rD1}, {32'h0, vecs[i].n_rd1});
            chk($sformatf("v%0d_nb_rd2", i), {32'h0, n_rD2}, {32'h0, vecs[i].n_rd2});
            chk($sformatf("v%0d_nb_busy1", i), {63'h0, n_busy1}, {63'h0, vecs[i].n_b1});
            chk($sformatf("v%0d_nb_busy2", i), {63'h0, n_busy2}, {63'h0, vecs[i].n_b2});
            tick();
        end

        // r5 written and marked busy, then reset dropped between clock edges
        {we, link_we, rd1_use_wr} = 3'b100;
        wR = 5'd5; wD = 32'hDEADBEEF; issue_valid = 1'b1; issue_reg = 5'd5;
        tick();
        we = 1'b0; issue_valid = 1'b0; issue_reg = 5'd0; rR1 = 5'd5; rR2 = 5'd0;
        #1;
        chk("pre_reset_r5", {32'h0, rD1}, 64'h0000_0000_DEAD_BEEF);
        chk("pre_reset_busy5", {63'h0, busy1}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_r5", {32'h0, rD1}, 64'h0);
        chk("async_reset_busy5", {63'h0, busy1}, 64'h0);
        we = 1'b1; wR = 5'd5; wD = 32'h55;
        #1;
        chk("reset_bypass_blocked", {32'h0, rD1}, 64'h0);
        tick();
        rst_n = 1'b1;
        we = 1'b0;
        #1;
        chk("reset_write_discarded", {32'h0, rD1}, 64'h0);
        tick();

        x_we = 1'b1; x_wR = 4'd15; x_wD = 64'hFFFF_0000_FFFF_0000;
        tick();
        x_wR = 4'd0; x_wD = 64'hFFFF_FFFF_FFFF_FFFF; x_rR1 = 4'd15; x_rR2 = 4'd0;
        #1;
        chk("wide_r15", x_rD1, 64'hFFFF_0000_FFFF_0000);
        chk("wide_r0_bypass", x_rD2, 64'h0);
        tick();
        x_we = 1'b0;
        #1;
        chk("wide_r0_stored", x_rD2, 64'h0);
        chk("wide_r15_hold", x_rD1, 64'hFFFF_0000_FFFF_0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
